// File: rtl/irq_pkg.sv
// Shared types and sizing helpers for the interrupt priority controller.
package irq_pkg;

  localparam int NUM_SRC_DEF = 8;

  // ID width for a given source count; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_priority_controller_if.sv
// Source, mask and CPU handshake bundle for the interrupt priority controller.
// master: the controller; slave: the CPU interrupt unit / software side.
interface irq_priority_controller_if import irq_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
);
  localparam int ID_W = id_w(NUM_SRC);

  logic [NUM_SRC-1:0] src_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_data;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_done;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  modport master (
    input  src_in, mask_we, mask_data, irq_ack, irq_done,
    output irq, irq_id, pending, busy
  );

  modport slave (
    output src_in, mask_we, mask_data, irq_ack, irq_done,
    input  irq, irq_id, pending, busy
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// Find-first-set over the enabled pending vector; lowest index wins.
module irq_priority_encoder import irq_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0]        req,
  output logic                      valid,
  output logic [id_w(NUM_SRC)-1:0]  index
);
  localparam int ID_W = id_w(NUM_SRC);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/irq_priority_controller.sv
// Latches interrupt events as pending, masks them, and hands exactly one
// interrupt at a time to the CPU over a req/ack/done handshake.
// Optional IRQ_EDGE_DETECT_EN: events are rising edges of the sources
// instead of high levels, so a held-high source pends only once.
module irq_priority_controller import irq_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  irq_priority_controller_if.master   bus
);
  localparam int ID_W = id_w(NUM_SRC);

  state_t             state, state_next;
  logic [NUM_SRC-1:0] pending, mask, events, clr;
  logic [ID_W-1:0]    irq_id;
  logic               sel_valid, load_id, take;
  logic [ID_W-1:0]    sel_index;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_prev;

  // Previous source sample for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_prev <= '0;
    else     src_prev <= bus.src_in;
  end

  assign events = bus.src_in & ~src_prev;
`else
  assign events = bus.src_in;
`endif

  // Selection looks only at registered state, keeping outputs input-free.
  irq_priority_encoder #(.NUM_SRC(NUM_SRC)) u_enc (
    .req   (pending & mask),
    .valid (sel_valid),
    .index (sel_index)
  );

  // Clear only the bit being acknowledged; a same-cycle event re-sets it.
  assign clr = take ? (NUM_SRC'(1) << irq_id) : '0;

  // Pending, mask and the latched ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      irq_id  <= '0;
    end else begin
      pending <= (pending & ~clr) | events;
      if (bus.mask_we) mask   <= bus.mask_data;
      if (load_id)     irq_id <= sel_index;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: pick a winner in IDLE, wait for ACK in REQ, DONE in SERVICE.
  always_comb begin
    state_next = state;
    load_id    = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_next = REQ;
          load_id    = 1'b1;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_next = SERVICE;
          take       = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.irq_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.irq     = (state == REQ);
  assign bus.busy    = (state == SERVICE);
  assign bus.irq_id  = irq_id;
  assign bus.pending = pending;
endmodule

// File: tb/tb_irq_priority_controller.sv
// Self-checking bench: directed test-plan scenarios followed by random
// traffic, all checked every cycle against a behavioural model.
module tb_irq_priority_controller;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_priority_controller_if #(.NUM_SRC(N)) bus();

  irq_priority_controller #(.NUM_SRC(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_req   = 0;
  bit irq_seen = 0;

  // Model: pending/mask as plain bit sets, phase 0 = nothing outstanding,
  // 1 = request posted to CPU, 2 = ISR running.
  bit [N-1:0] m_pend, m_mask, m_prev;
  int         m_phase, m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_phase = 0; m_id = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] ev, clr;
    int w;
    ev  = bus.src_in;
`ifdef IRQ_EDGE_DETECT_EN
    ev  = bus.src_in & ~m_prev;
`endif
    clr = '0;
    if (m_phase == 0) begin
      w = lowest(m_pend & m_mask);
      if (w >= 0) begin m_phase = 1; m_id = w; end
    end else if (m_phase == 1) begin
      if (bus.irq_ack) begin clr[m_id] = 1'b1; m_phase = 2; end
    end else begin
      if (bus.irq_done) m_phase = 0;
    end
    if (bus.mask_we) m_mask = bus.mask_data;
    m_pend = (m_pend & ~clr) | ev;
    m_prev = bus.src_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("irq",  bus.irq,     m_phase == 1);
    chk("busy", bus.busy,    m_phase == 2);
    chk("pend", bus.pending, m_pend);
    if (m_phase == 1) chk("id", bus.irq_id, m_id);
    if (bus.irq && !irq_seen) n_req++;
    irq_seen = bus.irq;
  endtask

  // Async reset from mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_irq",  bus.irq,     0);
    chk("rst_id",   bus.irq_id,  0);
    chk("rst_busy", bus.busy,    0);
    chk("rst_pend", bus.pending, 0);
    #1 rst = 1'b0;
    model_reset();
    irq_seen = 1'b0;
  endtask

  task automatic write_mask(input bit [N-1:0] m);
    bus.mask_we = 1'b1; bus.mask_data = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic pulse(input bit [N-1:0] s);
    bus.src_in = s;
    tick();
    bus.src_in = '0;
  endtask

  task automatic ack_done();
    bus.irq_ack = 1'b1;  tick(); bus.irq_ack = 1'b0;
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
  endtask

  initial begin
    int exp_req;
    bus.src_in = '0; bus.mask_we = 1'b0; bus.mask_data = '0;
    bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("init_irq",  bus.irq,     0);
    chk("init_id",   bus.irq_id,  0);
    chk("init_busy", bus.busy,    0);
    chk("init_pend", bus.pending, 0);
    rst = 1'b0;

    // Reset while a request for ID 3 is posted.
    write_mask(8'hFF);
    pulse(8'h08);
    tick();
    chk("pre_rst_irq", bus.irq, 1);
    chk("pre_rst_id",  bus.irq_id, 3);
    async_reset();
    repeat (3) tick();
    chk("post_rst_irq", bus.irq, 0);

    // Single source, two-edge latency.
    write_mask(8'hFF);
    pulse(8'h20);
    chk("single_pend", bus.pending, 8'h20);
    chk("single_noirq", bus.irq, 0);
    tick();
    chk("single_irq", bus.irq, 1);
    chk("single_id",  bus.irq_id, 5);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("single_busy", bus.busy, 1);
    chk("single_clr",  bus.pending, 0);
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
    chk("single_done", bus.busy, 0);

    // Priority and ID hold during REQ.
    pulse(8'h44);
    tick();
    chk("prio_id", bus.irq_id, 2);
    pulse(8'h01);
    chk("hold_id", bus.irq_id, 2);
    ack_done();
    tick();
    chk("prio_next0", bus.irq_id, 0);
    ack_done();
    tick();
    chk("prio_next6", bus.irq_id, 6);
    ack_done();

    // Masking gates selection but keeps the bit pending.
    write_mask(8'h00);
    pulse(8'h02);
    tick(); tick();
    chk("mask_pend",  bus.pending, 8'h02);
    chk("mask_noirq", bus.irq, 0);
    write_mask(8'h02);
    chk("mask_w0", bus.irq, 0);
    tick();
    chk("mask_irq", bus.irq, 1);
    chk("mask_id",  bus.irq_id, 1);
    ack_done();

    // Stray handshakes and set-beats-clear.
    write_mask(8'hFF);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("stray_ack", bus.busy, 0);
    pulse(8'h10);
    tick();
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
    chk("stray_done_irq",  bus.irq, 1);
    chk("stray_done_busy", bus.busy, 0);
    bus.irq_ack = 1'b1; bus.src_in = 8'h10; tick();
    bus.irq_ack = 1'b0; bus.src_in = '0;
    chk("set_wins", bus.pending[4], 1);
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
    tick();
    chk("repend_id", bus.irq_id, 4);
    ack_done();
    tick();

    // Held-high source: level re-requests, edge requests once.
    n_req = 0;
    for (int i = 0; i < 16; i++) begin
      bus.src_in   = (i < 10) ? 8'h08 : 8'h00;
      bus.irq_ack  = (m_phase == 1);
      bus.irq_done = (m_phase == 2);
      tick();
    end
    bus.src_in = '0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    exp_req = 1;
`else
    exp_req = 4;
`endif
    chk("held_reqs", n_req, exp_req);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.src_in    = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : '0;
      bus.mask_we   = ($urandom_range(0, 15) == 0);
      bus.mask_data = N'($urandom);
      bus.irq_ack   = ($urandom_range(0, 2) == 0);
      bus.irq_done  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
